// File: rtl/game_pkg.sv
// =============================================================================
// Module      : game_pkg
// Description : Shared state encodings and field widths for the game controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package game_pkg;

    localparam int c_STATE_W = 3;
    localparam int c_LIVES_W = 3;
    localparam int c_LEVEL_W = 4;

    localparam logic [c_LIVES_W-1:0] c_LIVES_SAT = 3'd7;
    localparam logic [c_LEVEL_W-1:0] c_LEVEL_ONE = 4'd1;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/game_fsm_phase_timer.sv
// =============================================================================
// Module      : phase_timer
// Description : Freeze/pause counter; clear holds it at zero, expire flags the
//               last cycle of an i_Limit-cycle phase.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Clear,
    input  logic [WIDTH-1:0] i_Limit,
    output logic             o_Expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_Expire = (r_count == (i_Limit - WIDTH'(1)));

endmodule

`default_nettype wire

// File: rtl/game_fsm.sv
// =============================================================================
// Module      : game_fsm
// Description : Frogger-style game controller: lives, levels, hit freeze and
//               level pause. Define GAME_FSM_BONUS_LIFE_EN for a bonus life on
//               level wrap.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module game_fsm
    import game_pkg::*;
#(
    parameter int START_LIVES        = 3,
    parameter int MAX_LEVEL          = 9,
    parameter int HIT_FREEZE_CYCLES  = 25000000,
    parameter int LEVEL_PAUSE_CYCLES = 12500000
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Start,
    input  logic                 i_Collision,
    input  logic                 i_Goal,
    output logic [c_STATE_W-1:0] o_State,
    output logic [c_LEVEL_W-1:0] o_Level,
    output logic [c_LIVES_W-1:0] o_Lives,
    output logic                 o_Freeze,
    output logic                 o_Respawn,
    output logic                 o_Game_Over
);

    localparam int c_TIMER_MAX = (HIT_FREEZE_CYCLES > LEVEL_PAUSE_CYCLES) ?
                                 HIT_FREEZE_CYCLES : LEVEL_PAUSE_CYCLES;
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX + 1);

    localparam logic [c_TIMER_W-1:0] c_HIT_LIMIT   = c_TIMER_W'(HIT_FREEZE_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_PAUSE_LIMIT = c_TIMER_W'(LEVEL_PAUSE_CYCLES);
    localparam logic [c_LIVES_W-1:0] c_START_LIVES = c_LIVES_W'(START_LIVES);
    localparam logic [c_LEVEL_W-1:0] c_MAX_LEVEL   = c_LEVEL_W'(MAX_LEVEL);

    state_t               r_state;
    logic [c_LIVES_W-1:0] r_lives;
    logic [c_LEVEL_W-1:0] r_level;
    logic                 r_freeze;
    logic                 r_respawn;
    logic                 r_game_over;

    logic                 w_timed;
    logic                 w_expire;
    logic [c_TIMER_W-1:0] w_limit;

    // Timer only runs in the two frozen phases and is cleared on the exit edge,
    // so it always reads zero on the first cycle of any state.
    assign w_timed = (r_state == ST_HIT) || (r_state == ST_LEVEL_UP);
    assign w_limit = (r_state == ST_HIT) ? c_HIT_LIMIT : c_PAUSE_LIMIT;

    phase_timer #(
        .WIDTH(c_TIMER_W)
    ) u_phase_timer (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Clear (!w_timed || w_expire),
        .i_Limit (w_limit),
        .o_Expire(w_expire)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= ST_IDLE;
            r_lives     <= c_START_LIVES;
            r_level     <= c_LEVEL_ONE;
            r_freeze    <= 1'b1;
            r_respawn   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_respawn <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_Start) begin
                        r_state   <= ST_PLAY;
                        r_freeze  <= 1'b0;
                        r_respawn <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Collision takes priority over a simultaneous goal.
                    if (i_Collision) begin
                        r_state  <= ST_HIT;
                        r_freeze <= 1'b1;
                        if (r_lives != '0) begin
                            r_lives <= r_lives - c_LIVES_W'(1);
                        end
                    end else if (i_Goal) begin
                        r_state  <= ST_LEVEL_UP;
                        r_freeze <= 1'b1;
                        if (r_level >= c_MAX_LEVEL) begin
                            r_level <= c_LEVEL_ONE;
`ifdef GAME_FSM_BONUS_LIFE_EN
                            if (r_lives != c_LIVES_SAT) begin
                                r_lives <= r_lives + c_LIVES_W'(1);
                            end
`endif
                        end else begin
                            r_level <= r_level + c_LEVEL_W'(1);
                        end
                    end
                end
                ST_HIT: begin
                    if (w_expire) begin
                        if (r_lives == '0) begin
                            r_state     <= ST_GAME_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state   <= ST_PLAY;
                            r_freeze  <= 1'b0;
                            r_respawn <= 1'b1;
                        end
                    end
                end
                ST_LEVEL_UP: begin
                    if (w_expire) begin
                        r_state   <= ST_PLAY;
                        r_freeze  <= 1'b0;
                        r_respawn <= 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    if (i_Start) begin
                        r_state     <= ST_PLAY;
                        r_lives     <= c_START_LIVES;
                        r_level     <= c_LEVEL_ONE;
                        r_freeze    <= 1'b0;
                        r_respawn   <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_freeze    <= 1'b1;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign o_State     = r_state;
    assign o_Lives     = r_lives;
    assign o_Level     = r_level;
    assign o_Freeze    = r_freeze;
    assign o_Respawn   = r_respawn;
    assign o_Game_Over = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_game_fsm.sv
// =============================================================================
// Module      : tb_game_fsm
// Description : Self-checking bench for game_fsm: directed scenarios plus
//               random play against a countdown-based reference model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_game_fsm;

    localparam int START_LIVES = 3;
    localparam int MAX_LEVEL   = 3;
    localparam int HIT_CYC     = 4;
    localparam int PAUSE_CYC   = 3;
`ifdef GAME_FSM_BONUS_LIFE_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_HIT  = 2;
    localparam int M_LVL  = 3;
    localparam int M_OVER = 4;

    logic       clk = 1'b0;
    logic       rst, start, coll, goal;
    logic [2:0] state;
    logic [3:0] level;
    logic [2:0] lives;
    logic       freeze, respawn, game_over;

    always #5 clk = ~clk;

    game_fsm #(
        .START_LIVES       (START_LIVES),
        .MAX_LEVEL         (MAX_LEVEL),
        .HIT_FREEZE_CYCLES (HIT_CYC),
        .LEVEL_PAUSE_CYCLES(PAUSE_CYC)
    ) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_Start    (start),
        .i_Collision(coll),
        .i_Goal     (goal),
        .o_State    (state),
        .o_Level    (level),
        .o_Lives    (lives),
        .o_Freeze   (freeze),
        .o_Respawn  (respawn),
        .o_Game_Over(game_over)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus cycles remaining in it.
    int m_state = M_IDLE;
    int m_lives = START_LIVES;
    int m_level = 1;
    int m_left  = 0;
    bit m_resp  = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = M_IDLE;
            m_lives = START_LIVES;
            m_level = 1;
            m_left  = 0;
            m_resp  = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_resp = 1'b0;
            case (m_state)
                M_IDLE: if (start) begin
                    m_state = M_PLAY;
                    m_resp  = 1'b1;
                end
                M_PLAY: if (coll) begin
                    if (m_lives > 0) m_lives = m_lives - 1;
                    m_state = M_HIT;
                    m_left  = HIT_CYC;
                end else if (goal) begin
                    if (m_level == MAX_LEVEL) begin
                        m_level = 1;
                        if (BONUS && m_lives < 7) m_lives = m_lives + 1;
                    end else begin
                        m_level = m_level + 1;
                    end
                    m_state = M_LVL;
                    m_left  = PAUSE_CYC;
                end
                M_HIT: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_lives == 0) begin
                            m_state = M_OVER;
                        end else begin
                            m_state = M_PLAY;
                            m_resp  = 1'b1;
                        end
                    end
                end
                M_LVL: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_state = M_PLAY;
                        m_resp  = 1'b1;
                    end
                end
                M_OVER: if (start) begin
                    m_state = M_PLAY;
                    m_lives = START_LIVES;
                    m_level = 1;
                    m_resp  = 1'b1;
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_state", state, m_state);
            chk("model_lives", lives, m_lives);
            chk("model_level", level, m_level);
            chk("model_freeze", freeze, (m_state != M_PLAY) ? 1 : 0);
            chk("model_respawn", respawn, m_resp ? 1 : 0);
            chk("model_game_over", game_over, (m_state == M_OVER) ? 1 : 0);
        end
    end

    task automatic step(input bit s, input bit c, input bit g, input bit r);
        start = s;
        coll  = c;
        goal  = g;
        rst   = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hits;
        int resp_cnt;
        start = 1'b0;
        coll  = 1'b0;
        goal  = 1'b0;
        rst   = 1'b1;

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset_state", state, 0);
        chk("reset_lives", lives, 3);
        chk("reset_level", level, 1);
        chk("reset_freeze", freeze, 1);
        chk("reset_game_over", game_over, 0);
        chk("reset_respawn", respawn, 0);

        step(1, 0, 0, 0);
        chk("start_state", state, 1);
        chk("start_respawn", respawn, 1);
        chk("start_freeze", freeze, 0);
        chk("start_lives", lives, 3);
        step(0, 0, 0, 0);
        chk("start_respawn_once", respawn, 0);

        // Collision held through the whole freeze costs one life only.
        hits     = 0;
        resp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            if (i == 0) chk("hit_lives_dec", lives, 2);
            if (state == 3'd2) hits++;
            if (respawn) resp_cnt++;
        end
        step(0, 0, 0, 0);
        chk("hit_cycles", hits, 4);
        chk("hit_respawns", resp_cnt, 1);
        chk("hit_back_play", state, 1);
        chk("hit_lives_once", lives, 2);

        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("last_life_lives", lives, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("last_hit_still_hit", state, 2);
        step(0, 0, 0, 0);
        chk("game_over_state", state, 4);
        chk("game_over_flag", game_over, 1);
        step(1, 0, 0, 0);
        chk("restart_state", state, 1);
        chk("restart_lives", lives, 3);
        chk("restart_level", level, 1);
        chk("restart_respawn", respawn, 1);

        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0);
            chk("goal_level", level, (k == 2) ? 1 : k + 2);
            chk("goal_state", state, 3);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
            chk("pause_hold", state, 3);
            step(0, 0, 0, 0);
            chk("pause_exit", state, 1);
            chk("pause_respawn", respawn, 1);
        end
        chk("wrap_lives", lives, BONUS ? 4 : 3);

        step(0, 1, 1, 0);
        chk("both_state", state, 2);
        chk("both_level", level, 1);
        chk("both_lives", lives, BONUS ? 3 : 2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("midhit_reset_state", state, 0);
        chk("midhit_reset_lives", lives, 3);
        chk("midhit_reset_freeze", freeze, 1);
        resp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0);
            if (respawn) resp_cnt++;
        end
        chk("midhit_no_respawn", resp_cnt, 0);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 249) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
